pkt_assembler_pld: RTL and testbench
====================================

Name: pkt_assembler_pld

Overview:
- Next-generation SpiNNaker multicast packet assembler. Maps incoming events to routing keys through NUM_MREGS mask/shift fields OR-ed onto a base key.
- Shifts are bidirectional: each field can shift left or right.
- Events may carry an optional 32-bit payload.
- A 2-entry output buffer sustains one packet per cycle under continuous pkt_rdy_in.
- Sits between the event source (e.g. peripheral input) and the SpiNNaker packet transmitter.

Parameters:
PACKET_BITS, 72, output packet width: payload[71:40], key[39:8], header[7:0]
NUM_MREGS, 4, number of mask/shift mapping fields (1..16)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mp_key_in  in  32  base routing key
field_msk_in  in  32 x NUM_MREGS  per-field mask
field_sft_in  in  6 x NUM_MREGS  per-field signed shift; >=0 shifts right, <0 shifts left
evt_data_in  in  32  event data
evt_pld_in  in  32  event payload
evt_pld_vld_in  in  1  payload present with this event
evt_vld_in  in  1  event valid
evt_rdy_out  out  1  event ready (registered)
pkt_data_out  out  PACKET_BITS  packet
pkt_vld_out  out  1  packet valid
pkt_rdy_in  in  1  packet ready
pkt_cnt_clr_in  in  1  synchronous counter clear (only with PKT_ASSEMBLER_CNT_EN)
pkt_cnt_out  out  32  sent-packet count (only with PKT_ASSEMBLER_CNT_EN)

Behaviour:
- Reset (asynchronous, reset_n low): buffer empty; evt_rdy_out=0; pkt_vld_out=0; pkt_data_out=0; pkt_cnt_out=0.
- Mapping is combinational on the accepted event:
  - field_i = (evt_data_in & msk_i) shifted by s_i = field_sft_in[i], a 6-bit two's-complement value.
  - s_i >= 0: logical right shift by s_i. s_i < 0: left shift by -s_i. s_i = -32: field is 0.
  - key = mp_key_in | OR of all field_i.
- Packet construction:
  - Payload = evt_pld_in if evt_pld_vld_in, else 0.
  - header[1] = evt_pld_vld_in. header[7:2] = 0 (multicast).
  - header[0] = odd parity over key, payload and header[7:1]. Total set bits in the 72-bit packet is odd.
- Transfers: input transfer when evt_vld_in && evt_rdy_out; output transfer when pkt_vld_out && pkt_rdy_in.
- Buffer: 2-entry FIFO of constructed packets.
  - pkt_data_out is the head entry, registered. pkt_vld_out = (count != 0).
  - Head data is stable while pkt_vld_out && !pkt_rdy_in.
- Latency: event accepted at edge N with buffer empty → pkt_vld_out=1 with that packet from edge N (visible cycle N+1).
- Simultaneous input and output transfer: count unchanged; order preserved.
- evt_rdy_out: registered, equals (count_next < 2). Full buffer → 0; an output transfer from full raises it the next cycle. First cycle after reset release → 1.
- No event loss or duplication under any evt_vld_in/pkt_rdy_in pattern. pkt_vld_out never drops without an output transfer.
- Configuration inputs are sampled only at input transfer. Changes affect only later events.
- Reset asserted mid-operation discards buffered packets immediately.

Optional Feature:
- Macro PKT_ASSEMBLER_CNT_EN.
- Defined:
  - pkt_cnt_out increments by 1 on each output transfer and wraps 0xFFFF_FFFF→0.
  - pkt_cnt_clr_in=1 sets it to 0 next edge. Clear has priority over a simultaneous increment.
- Undefined: pkt_cnt_clr_in is ignored; pkt_cnt_out ties to 0; no counter flops.

Test Plan:
1. mp_key=0, msk0=0xFF, sft0=0, other masks 0; evt_data=0x3, no payload, pkt_rdy_in=1 → one packet 0x00_0000_0000_0000_0301 (key 0x3, hdr 0x01), next cycle after acceptance.
2. Same mapping, evt_data=0x3, evt_pld=0x1 with evt_pld_vld_in=1 → packet {0x0000_0001, 0x0000_0003, 0x03}.
3. mp_key=0xAB00_0000, msk1=0xF, sft1=6'h3C (-4), evt_data=0xF → key 0xAB00_00F0. Then sft1=4 → key 0xAB00_0000.
4. pkt_rdy_in=0, stream 3 events 0x1, 0x2, 0x3:
   - first two accepted, evt_rdy_out=0 after the second;
   - raising pkt_rdy_in delivers 0x1, 0x2, 0x3 in order, with no gaps under continuous valid.
5. Random evt_vld_in/pkt_rdy_in (50% each), 1000 events → scoreboard matches exactly; head data stable while stalled.
6. Reset pulse with 2 packets buffered → pkt_vld_out=0, evt_rdy_out=0 immediately. With CNT_EN: count 5, then pkt_cnt_clr_in with a simultaneous transfer → 0.

Source files
------------

// File: rtl/pkt_assembler_pld.sv
// Multicast packet assembler: maps events to routing keys and queues packets in a 2-entry buffer.
// Optional sent-packet counter enabled by defining PKT_ASSEMBLER_CNT_EN.
module pkt_assembler_pld #(
  parameter int unsigned PACKET_BITS = 72,
  parameter int unsigned NUM_MREGS   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [31:0]               mp_key_in,
  input  logic [32*NUM_MREGS-1:0]   field_msk_in,
  input  logic [6*NUM_MREGS-1:0]    field_sft_in,
  input  logic [31:0]               evt_data_in,
  input  logic [31:0]               evt_pld_in,
  input  logic                      evt_pld_vld_in,
  input  logic                      evt_vld_in,
  output logic                      evt_rdy_out,
  output logic [PACKET_BITS-1:0]    pkt_data_out,
  output logic                      pkt_vld_out,
  input  logic                      pkt_rdy_in,
  input  logic                      pkt_cnt_clr_in,
  output logic [31:0]               pkt_cnt_out
);

  logic [31:0]            key;
  logic [31:0]            masked;
  logic [5:0]             sft;
  logic [5:0]             amt;
  logic [31:0]            pld;
  logic [7:0]             hdr;
  logic [PACKET_BITS-1:0] new_pkt;

  always_comb begin
    key    = mp_key_in;
    masked = '0;
    sft    = '0;
    amt    = '0;
    for (int i = 0; i < NUM_MREGS; i++) begin
      masked = evt_data_in & field_msk_in[32*i +: 32];
      sft    = field_sft_in[6*i +: 6];
      amt    = -sft;
      if (!sft[5]) begin
        key = key | (masked >> sft[4:0]);
      end else if (!amt[5]) begin
        // amt[5] set only for a shift of -32, which empties the field
        key = key | (masked << amt[4:0]);
      end
    end
  end

  always_comb begin
    pld      = evt_pld_vld_in ? evt_pld_in : 32'h0;
    hdr[7:1] = {6'b0, evt_pld_vld_in};
    hdr[0]   = ~^{pld, key, hdr[7:1]};
    new_pkt  = {pld, key, hdr};
  end

  logic                   push;
  logic                   pop;
  logic [1:0]             cnt_q, cnt_d;
  logic [PACKET_BITS-1:0] head_q, head_d;
  logic [PACKET_BITS-1:0] tail_q, tail_d;
  logic                   rdy_q;

  assign push         = evt_vld_in && rdy_q;
  assign pop          = pkt_vld_out && pkt_rdy_in;
  assign pkt_vld_out  = (cnt_q != 2'd0);
  assign pkt_data_out = head_q;
  assign evt_rdy_out  = rdy_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = new_pkt;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_pkt;
        end else if (push) begin
          tail_d = new_pkt;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = new_pkt;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= (cnt_d < 2'd2);
    end
  end

`ifdef PKT_ASSEMBLER_CNT_EN
  logic [31:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= 32'h0;
    end else if (pkt_cnt_clr_in) begin
      pkt_cnt_q <= 32'h0;
    end else if (pop) begin
      pkt_cnt_q <= pkt_cnt_q + 32'h1;
    end
  end

  assign pkt_cnt_out = pkt_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = pkt_cnt_clr_in;
  assign pkt_cnt_out    = 32'h0;
`endif

endmodule

// File: tb/tb_pkt_assembler_pld.sv
// Scoreboard bench for pkt_assembler_pld: directed mapping, backpressure, random traffic, reset.
module tb_pkt_assembler_pld;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  mp_key_in;
  logic [127:0] field_msk_in;
  logic [23:0]  field_sft_in;
  logic [31:0]  evt_data_in;
  logic [31:0]  evt_pld_in;
  logic         evt_pld_vld_in;
  logic         evt_vld_in;
  logic         evt_rdy_out;
  logic [71:0]  pkt_data_out;
  logic         pkt_vld_out;
  logic         pkt_rdy_in;
  logic         pkt_cnt_clr_in;
  logic [31:0]  pkt_cnt_out;

  pkt_assembler_pld #(
    .PACKET_BITS(72),
    .NUM_MREGS  (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mp_key_in     (mp_key_in),
    .field_msk_in  (field_msk_in),
    .field_sft_in  (field_sft_in),
    .evt_data_in   (evt_data_in),
    .evt_pld_in    (evt_pld_in),
    .evt_pld_vld_in(evt_pld_vld_in),
    .evt_vld_in    (evt_vld_in),
    .evt_rdy_out   (evt_rdy_out),
    .pkt_data_out  (pkt_data_out),
    .pkt_vld_out   (pkt_vld_out),
    .pkt_rdy_in    (pkt_rdy_in),
    .pkt_cnt_clr_in(pkt_cnt_clr_in),
    .pkt_cnt_out   (pkt_cnt_out)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          n_popped = 0;
  logic [31:0] exp_cnt = 32'h0;
  logic [71:0] sb[$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] model(input logic [31:0] key0, input logic [31:0] data,
                                        input logic [31:0] pld, input logic pv,
                                        input logic [127:0] msk, input logic [23:0] sft);
    logic [31:0] k;
    logic [31:0] m;
    logic [31:0] pl;
    logic [7:0]  h;
    int          s;
    k = key0;
    for (int i = 0; i < 4; i++) begin
      m = data & msk[32*i +: 32];
      s = int'($signed(sft[6*i +: 6]));
      if (s >= 0) k = k | (m >> s);
      else if (s > -32) k = k | (m << (-s));
    end
    pl   = pv ? pld : 32'h0;
    h    = {6'b0, pv, 1'b0};
    h[0] = ($countones({pl, k, h[7:1]}) % 2) == 0;
    return {pl, k, h};
  endfunction

  // One clock: check pops and record pushes before the edge, stall hold after it.
  task automatic tick(output bit acc);
    logic        hold;
    logic [71:0] hd;
    logic [71:0] exp;
    @(negedge clk);
    acc = evt_vld_in && evt_rdy_out;
    if (pkt_vld_out && pkt_rdy_in) begin
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      chk("pop_order", pkt_data_out, exp);
      n_popped++;
    end
`ifdef PKT_ASSEMBLER_CNT_EN
    if (pkt_cnt_clr_in) exp_cnt = 32'h0;
    else if (pkt_vld_out && pkt_rdy_in) exp_cnt = exp_cnt + 32'h1;
`endif
    if (acc) sb.push_back(model(mp_key_in, evt_data_in, evt_pld_in, evt_pld_vld_in,
                                field_msk_in, field_sft_in));
    hold = pkt_vld_out && !pkt_rdy_in;
    hd   = pkt_data_out;
    @(posedge clk);
    #1;
    if (hold) begin
      chk("stall_vld", 72'(pkt_vld_out), 72'd1);
      chk("stall_data", pkt_data_out, hd);
    end
    chk("pkt_cnt", 72'(pkt_cnt_out), 72'(exp_cnt));
  endtask

  initial begin
    bit acc;
    int sent;
    int p0;
    reset_n        = 1'b0;
    mp_key_in      = '0;
    field_msk_in   = '0;
    field_sft_in   = '0;
    evt_data_in    = '0;
    evt_pld_in     = '0;
    evt_pld_vld_in = 1'b0;
    evt_vld_in     = 1'b0;
    pkt_rdy_in     = 1'b0;
    pkt_cnt_clr_in = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 72'(pkt_vld_out), 72'd0);
    chk("rst_rdy", 72'(evt_rdy_out), 72'd0);
    chk("rst_data", pkt_data_out, 72'd0);
    chk("rst_cnt", 72'(pkt_cnt_out), 72'd0);
    reset_n = 1'b1;
    tick(acc);
    chk("rdy_after_rst", 72'(evt_rdy_out), 72'd1);

    // Basic mapping, no payload
    field_msk_in = {96'b0, 32'hFF};
    evt_data_in  = 32'h3;
    pkt_rdy_in   = 1'b1;
    evt_vld_in   = 1'b1;
    tick(acc);
    evt_vld_in = 1'b0;
    chk("t1_acc", 72'(acc), 72'd1);
    chk("t1_vld", 72'(pkt_vld_out), 72'd1);
    chk("t1_pkt", pkt_data_out, 72'h00_0000_0000_0000_0301);
    tick(acc);

    // With payload
    evt_pld_in     = 32'h1;
    evt_pld_vld_in = 1'b1;
    evt_vld_in     = 1'b1;
    tick(acc);
    evt_vld_in = 1'b0;
    chk("t2_pkt", pkt_data_out, {32'h1, 32'h3, 8'h03});
    tick(acc);

    // Bidirectional shift on field 1
    evt_pld_vld_in = 1'b0;
    mp_key_in      = 32'hAB00_0000;
    field_msk_in   = {64'b0, 32'hF, 32'h0};
    field_sft_in   = {12'b0, 6'h3C, 6'h0};
    evt_data_in    = 32'hF;
    evt_vld_in     = 1'b1;
    tick(acc);
    chk("t3_key_left", 72'(pkt_data_out[39:8]), 72'h0000_AB00_00F0);
    field_sft_in = {12'b0, 6'h04, 6'h0};
    tick(acc);
    evt_vld_in = 1'b0;
    chk("t3_key_right", 72'(pkt_data_out[39:8]), 72'h0000_AB00_0000);
    tick(acc);

    // Backpressure: buffer fills at two, then drains in order without gaps
    mp_key_in    = '0;
    field_msk_in = {96'b0, 32'hFFFF_FFFF};
    field_sft_in = '0;
    pkt_rdy_in   = 1'b0;
    evt_vld_in   = 1'b1;
    evt_data_in  = 32'h1;
    tick(acc);
    chk("t4_acc1", 72'(acc), 72'd1);
    evt_data_in = 32'h2;
    tick(acc);
    chk("t4_acc2", 72'(acc), 72'd1);
    chk("t4_rdy_low", 72'(evt_rdy_out), 72'd0);
    evt_data_in = 32'h3;
    tick(acc);
    chk("t4_acc3_blocked", 72'(acc), 72'd0);
    pkt_rdy_in = 1'b1;
    p0 = n_popped;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      if (acc) evt_vld_in = 1'b0;
    end
    evt_vld_in = 1'b0;
    chk("t4_no_gaps", 72'(n_popped - p0), 72'd3);
    chk("t4_empty", 72'(sb.size()), 72'd0);

    // Random traffic against the scoreboard
    sent = 0;
    for (int k = 0; k < 20000 && sent < 1000; k++) begin
      evt_vld_in     = 1'($urandom_range(0, 1));
      pkt_rdy_in     = 1'($urandom_range(0, 1));
      pkt_cnt_clr_in = ($urandom_range(0, 19) == 0);
      mp_key_in      = (k % 4 == 0) ? $urandom : 32'h0;
      field_msk_in   = {$urandom, $urandom, $urandom, $urandom};
      field_sft_in   = {6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom)};
      evt_data_in    = $urandom;
      evt_pld_in     = $urandom;
      evt_pld_vld_in = 1'($urandom_range(0, 1));
      tick(acc);
      if (acc) sent++;
    end
    chk("t5_sent", 72'(sent), 72'd1000);
    evt_vld_in     = 1'b0;
    pkt_rdy_in     = 1'b1;
    pkt_cnt_clr_in = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick(acc);
    chk("t5_drained", 72'(sb.size()), 72'd0);

    // Asynchronous reset with two packets buffered
    pkt_rdy_in = 1'b0;
    evt_vld_in = 1'b1;
    tick(acc);
    tick(acc);
    evt_vld_in = 1'b0;
    chk("t6_full", 72'(evt_rdy_out), 72'd0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_vld", 72'(pkt_vld_out), 72'd0);
    chk("t6_rst_rdy", 72'(evt_rdy_out), 72'd0);
    chk("t6_rst_data", pkt_data_out, 72'd0);
    chk("t6_rst_cnt", 72'(pkt_cnt_out), 72'd0);
    sb.delete();
    exp_cnt = 32'h0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(acc);
    chk("t6_rdy_back", 72'(evt_rdy_out), 72'd1);

    // Counter: five transfers, then clear alongside a transfer
    pkt_rdy_in = 1'b1;
    evt_vld_in = 1'b1;
    sent = 0;
    for (int k = 0; k < 20 && sent < 5; k++) begin
      tick(acc);
      if (acc) sent++;
    end
    evt_vld_in = 1'b0;
    tick(acc);
`ifdef PKT_ASSEMBLER_CNT_EN
    chk("t6_cnt5", 72'(pkt_cnt_out), 72'd5);
`else
    chk("t6_cnt5", 72'(pkt_cnt_out), 72'd0);
`endif
    evt_vld_in = 1'b1;
    tick(acc);
    evt_vld_in     = 1'b0;
    pkt_cnt_clr_in = 1'b1;
    chk("t6_clr_xfer", 72'(pkt_vld_out), 72'd1);
    tick(acc);
    pkt_cnt_clr_in = 1'b0;
    chk("t6_cnt_clr", 72'(pkt_cnt_out), 72'd0);
    tick(acc);
    chk("t6_final_empty", 72'(sb.size()), 72'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
